// File: rtl/image_write_buffer.sv
// Frame capture buffer: stores one RGB888 frame in BMP byte order and replays it as a byte stream.
// Optional macro BMP_HEADER_EN prefixes the 54-byte BMP file header to the stream.
module image_write_buffer #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       VSYNC,
  input  logic       HSYNC,
  input  logic [7:0] DATA_R0,
  input  logic [7:0] DATA_G0,
  input  logic [7:0] DATA_B0,
  input  logic [7:0] DATA_R1,
  input  logic [7:0] DATA_G1,
  input  logic [7:0] DATA_B1,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_done,
  output logic       busy,
  output logic       err_frame
);

  localparam int NPIX_BYTES = WIDTH * HEIGHT * 3;
  localparam int NWORDS     = WIDTH * HEIGHT / 2;
  localparam int AW         = (NWORDS > 1) ? $clog2(NWORDS) : 1;
`ifdef BMP_HEADER_EN
  localparam int HDR_LEN    = 54;
`else
  localparam int HDR_LEN    = 0;
`endif
  localparam int TOTAL      = HDR_LEN + NPIX_BYTES;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_READOUT} state_t;

  state_t        r_state, w_state_nxt;
  logic [10:0]   r_col;
  logic [9:0]    r_row;
  logic [20:0]   r_rd_addr;
  logic [AW-1:0] r_rd_word;
  logic [2:0]    r_rd_sub;
  logic [7:0]    r_out_data;
  logic          r_out_valid, r_out_last, r_frame_done, r_err;

  // A pair's base address is always a multiple of 6, so one 48-bit word holds exactly one pair.
  logic [47:0]   r_mem [NWORDS];

  logic [AW-1:0] w_wr_word;
  logic          w_wr_en, w_last_pair, w_restart, w_done_rd, w_load, w_in_hdr;
  logic [47:0]   w_pix_word;
  logic [7:0]    w_pix_byte, w_byte;

  assign w_wr_word   = AW'((WIDTH / 2) * (HEIGHT - 1 - int'(r_row)) + int'(r_col >> 1));
  assign w_wr_en     = HSYNC && ((r_state == S_ARMED) || (r_state == S_CAPTURE && !VSYNC));
  assign w_last_pair = (r_row == 10'(HEIGHT - 1)) && (r_col == 11'(WIDTH - 2));
  assign w_restart   = (r_state == S_CAPTURE) && VSYNC;
  assign w_done_rd   = (r_state == S_READOUT) && r_out_valid && out_ready && r_out_last;
  assign w_load      = (r_state == S_READOUT) && (!r_out_valid || (out_ready && !r_out_last));

  assign w_pix_word  = r_mem[r_rd_word];
  assign w_pix_byte  = w_pix_word[r_rd_sub*8 +: 8];

`ifdef BMP_HEADER_EN
  function automatic logic [7:0] hdr_byte(input logic [20:0] i);
    logic [31:0] f;
    int          o;
    f = '0;
    o = 0;
    if      (i < 2)  begin f = 32'h0000_4D42;        o = int'(i);      end
    else if (i < 6)  begin f = 32'(54 + NPIX_BYTES); o = int'(i) - 2;  end
    else if (i < 10) begin f = '0;                   o = 0;            end
    else if (i < 14) begin f = 32'd54;               o = int'(i) - 10; end
    else if (i < 18) begin f = 32'd40;               o = int'(i) - 14; end
    else if (i < 22) begin f = 32'(WIDTH);           o = int'(i) - 18; end
    else if (i < 26) begin f = 32'(HEIGHT);          o = int'(i) - 22; end
    else if (i < 28) begin f = 32'd1;                o = int'(i) - 26; end
    else if (i < 30) begin f = 32'd24;               o = int'(i) - 28; end
    else if (i < 34) begin f = '0;                   o = 0;            end
    else if (i < 38) begin f = 32'(NPIX_BYTES);      o = int'(i) - 34; end
    return f[o*8 +: 8];
  endfunction

  assign w_in_hdr = (r_rd_addr < 21'(HDR_LEN));
  assign w_byte   = w_in_hdr ? hdr_byte(r_rd_addr) : w_pix_byte;
`else
  assign w_in_hdr = 1'b0;
  assign w_byte   = w_pix_byte;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (VSYNC) w_state_nxt = S_ARMED;
      S_ARMED:   if (w_wr_en) w_state_nxt = w_last_pair ? S_READOUT : S_CAPTURE;
      S_CAPTURE: begin
        if (w_restart)                   w_state_nxt = S_ARMED;
        else if (w_wr_en && w_last_pair) w_state_nxt = S_READOUT;
      end
      S_READOUT: if (w_done_rd) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge HCLK) begin
    if (w_wr_en) r_mem[w_wr_word] <= {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_col        <= '0;
      r_row        <= '0;
      r_rd_addr    <= '0;
      r_rd_word    <= '0;
      r_rd_sub     <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= w_wr_en && w_last_pair;
      if (w_restart || (r_state == S_READOUT && HSYNC)) r_err <= 1'b1;

      if ((r_state == S_IDLE && VSYNC) || w_restart) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_wr_en) begin
        if (r_col == 11'(WIDTH - 2)) begin
          r_col <= '0;
          r_row <= r_row + 10'd1;
        end else begin
          r_col <= r_col + 11'd2;
        end
      end

      // Final pair arms the reader; the following cycle is the prefetch cycle.
      if (w_wr_en && w_last_pair) begin
        r_rd_addr   <= '0;
        r_rd_word   <= '0;
        r_rd_sub    <= '0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else if (w_load) begin
        r_out_data  <= w_byte;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_rd_addr == 21'(TOTAL - 1));
        r_rd_addr   <= r_rd_addr + 21'd1;
        if (!w_in_hdr) begin
          if (r_rd_sub == 3'd5) begin
            r_rd_sub  <= '0;
            r_rd_word <= r_rd_word + AW'(1);
          end else begin
            r_rd_sub  <= r_rd_sub + 3'd1;
          end
        end
      end else if (w_done_rd) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign busy       = (r_state == S_CAPTURE) || (r_state == S_READOUT);
  assign err_frame  = r_err;

endmodule

// File: tb/tb_image_write_buffer.sv
// Scoreboard bench for image_write_buffer (4x2 frame); honours BMP_HEADER_EN if defined.
module tb_image_write_buffer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NB = W * H * 3;

  logic       HCLK = 1'b0;
  logic       HRESET, VSYNC, HSYNC, out_ready;
  logic [7:0] DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
  logic [7:0] out_data;
  logic       out_valid, out_last, frame_done, busy, err_frame;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_mem [NB];
  logic [7:0] exp_q [$];

  image_write_buffer #(.WIDTH(W), .HEIGHT(H)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_done(frame_done), .busy(busy), .err_frame(err_frame)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic pulse_reset;
    HRESET = 1'b1; VSYNC = 1'b0; HSYNC = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic push_le(input int val, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'((val >> (8 * i)) & 255));
  endtask

  // Drive one pair at the current negedge; upd=0 leaves the model untouched (aborted data).
  task automatic send_pair(input int r, input int c, input int seed, input bit upd);
    int base;
    HSYNC   = 1'b1;
    DATA_R0 = 8'(16 * r + c + seed);     DATA_G0 = 8'(8'h80 + c + seed);     DATA_B0 = 8'(8'hF0 + r + seed);
    DATA_R1 = 8'(16 * r + c + 1 + seed); DATA_G1 = 8'(8'h80 + c + 1 + seed); DATA_B1 = 8'(8'hF0 + r + seed);
    if (upd) begin
      base = W * 3 * (H - 1 - r) + 3 * c;
      exp_mem[base + 0] = DATA_B0; exp_mem[base + 1] = DATA_G0; exp_mem[base + 2] = DATA_R0;
      exp_mem[base + 3] = DATA_B1; exp_mem[base + 4] = DATA_G1; exp_mem[base + 5] = DATA_R1;
    end
    @(negedge HCLK);
  endtask

  // Capture one full frame, check frame_done/prefetch timing, load the expected stream.
  task automatic send_frame(input int seed, input bit gap);
    HSYNC = 1'b0; VSYNC = 1'b1;
    @(negedge HCLK);
    VSYNC = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c += 2) begin
        if (gap && c == 0 && r > 0) begin HSYNC = 1'b0; @(negedge HCLK); end
        send_pair(r, c, seed, 1'b1);
      end
    HSYNC = 1'b0;
    n_checks++;
    if ({frame_done, busy, out_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL frame_done_pulse got fd/busy/valid=%b want 110", {frame_done, busy, out_valid});
    end
    @(negedge HCLK);
    n_checks++;
    if ({frame_done, busy, out_valid} !== 3'b011) begin
      n_fail++;
      $display("FAIL first_valid got fd/busy/valid=%b want 011", {frame_done, busy, out_valid});
    end
    exp_q.delete();
`ifdef BMP_HEADER_EN
    exp_q.push_back(8'h42); exp_q.push_back(8'h4D);
    push_le(54 + NB, 4); push_le(0, 4); push_le(54, 4); push_le(40, 4);
    push_le(W, 4); push_le(H, 4); push_le(1, 2); push_le(24, 2);
    push_le(0, 4); push_le(NB, 4); push_le(0, 4); push_le(0, 4); push_le(0, 4); push_le(0, 4);
`endif
    for (int i = 0; i < NB; i++) exp_q.push_back(exp_mem[i]);
  endtask

  // mode 0: ready always; mode 1: ready 1,0,0,1 repeating. hs_inj pulses HSYNC during readout.
  task automatic drain(input int mode, input bit hs_inj);
    int         cyc, idx;
    bit         rdy, pv_stall;
    logic [7:0] pd;
    logic       pl;
    cyc = 0; idx = 0; pv_stall = 1'b0; pd = '0; pl = 1'b0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL valid_hold idx %0d got valid=%b want 1", idx, out_valid);
      end
      if (pv_stall) begin
        n_checks++;
        if (out_data !== pd || out_last !== pl) begin
          n_fail++;
          $display("FAIL stall_stable idx %0d got %h/%b want %h/%b", idx, out_data, out_last, pd, pl);
        end
      end
      rdy = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      out_ready = rdy;
      if (out_valid === 1'b1 && rdy) begin
        n_checks++;
        if (out_data !== exp_q[0] || out_last !== (exp_q.size() == 1)) begin
          n_fail++;
          $display("FAIL stream_byte idx %0d got %h last=%b want %h last=%b",
                   idx, out_data, out_last, exp_q[0], exp_q.size() == 1);
        end
        void'(exp_q.pop_front());
        idx++;
      end
      pv_stall = (out_valid === 1'b1) && !rdy;
      pd = out_data; pl = out_last;
      HSYNC   = hs_inj && (cyc % 7 == 2);
      DATA_R0 = 8'($urandom); DATA_G0 = 8'($urandom); DATA_B0 = 8'($urandom);
      cyc++;
      @(negedge HCLK);
    end
    HSYNC = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (cyc >= 3000) begin
      n_fail++;
      $display("FAIL drain_timeout got %0d bytes left want 0", exp_q.size());
    end
    n_checks++;
    if ({out_valid, out_last, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL stream_end got valid/last/busy=%b want 000", {out_valid, out_last, busy});
    end
  endtask

  task automatic test_reset;
    pulse_reset();
    n_checks++;
    if ({out_data, out_valid, out_last, frame_done, busy, err_frame} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_state got %h/%b%b%b%b%b want all 0",
               out_data, out_valid, out_last, frame_done, busy, err_frame);
    end
  endtask

  task automatic test_frame;
    send_frame(0, 1'b1);
    drain(0, 1'b0);
  endtask

  task automatic test_back_to_back_backpressure;
    send_frame(3, 1'b0);
    drain(1, 1'b0);
  endtask

  task automatic test_hsync_readout;
    n_checks++;
    if (err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clean got %b want 0", err_frame);
    end
    send_frame(7, 1'b0);
    drain(0, 1'b1);
    n_checks++;
    if (err_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL err_hsync_readout got %b want 1", err_frame);
    end
  endtask

  task automatic test_reset_readout;
    send_frame(9, 1'b0);
    out_ready = 1'b1;
    repeat (5) @(negedge HCLK);
    HRESET = 1'b1;
    #1;
    n_checks++;
    if ({out_data, out_valid, out_last, frame_done, busy, err_frame} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_readout got %h/%b%b%b%b%b want all 0",
               out_data, out_valid, out_last, frame_done, busy, err_frame);
    end
    @(negedge HCLK);
    HRESET = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    @(negedge HCLK);
  endtask

  task automatic test_vsync_restart;
    HSYNC = 1'b0; VSYNC = 1'b1;
    @(negedge HCLK);
    VSYNC = 1'b0;
    send_pair(0, 0, 8'h55, 1'b0);
    send_pair(0, 2, 8'h55, 1'b0);
    send_frame(12, 1'b0);
    n_checks++;
    if (err_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL err_vsync_restart got %b want 1", err_frame);
    end
    drain(1, 1'b0);
  endtask

  initial begin
    HRESET = 1'b1; VSYNC = 1'b0; HSYNC = 1'b0; out_ready = 1'b0;
    DATA_R0 = '0; DATA_G0 = '0; DATA_B0 = '0; DATA_R1 = '0; DATA_G1 = '0; DATA_B1 = '0;
    test_reset();
    test_frame();
    test_back_to_back_backpressure();
    test_hsync_readout();
    test_reset_readout();
    test_vsync_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
